instr_mem_loader: RTL and testbench

- Parametrised instruction memory for the single-cycle/pipelined core, with a 1-cycle registered fetch port and a streaming program-load port.
- Replaces the fixed 512x32 combinational table; the core fetches from it and the test harness or a boot block loads it.
- Load and fetch are mutually exclusive: fetch is blocked while a load is in progress.

---
 rtl/instr_mem_loader.sv | 164 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction RAM with a 1-cycle registered fetch port and a streaming program-load port.
// Optional macro INSTR_PARITY_EN adds a stored even-parity bit per word and a parity_err output.
module instr_mem_loader #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 512,
    parameter int    ADDR_W    = 32,
    parameter string INIT_FILE = "instruction_memory.mem"
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_req,
    input  logic [ADDR_W-1:0]      fetch_addr,
    input  logic                   fetch_stall,
    output logic [DATA_W-1:0]      instr,
    output logic                   instr_valid,
    output logic                   misaligned_err,
    output logic                   oob_err,
`ifdef INSTR_PARITY_EN
    output logic                   parity_err,
`endif
    input  logic                   load_start,
    input  logic                   load_valid,
    input  logic [DATA_W-1:0]      load_data,
    input  logic                   load_last,
    output logic                   load_ready,
    output logic                   load_busy,
    output logic                   load_done,
    output logic                   load_overflow,
    output logic [$clog2(DEPTH):0] load_count
);
    localparam int AW = $clog2(DEPTH);
`ifdef INSTR_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state_q;
    logic [AW:0]       cnt_q;
    logic              load_ready_q;
    logic              load_busy_q;
    logic              load_done_q;
    logic              load_ovf_q;
    logic              valid_q;
    logic              mis_q;
    logic              oob_q;
    logic              have_q;
    logic [MEM_W-1:0]  mem_q [DEPTH];
    logic [MEM_W-1:0]  rdata_q;

    logic [ADDR_W-3:0] word_idx;
    logic [AW-1:0]     rd_idx;
    logic              fetch_oob;
    logic              fetch_acc;
    logic              wr_en;
    logic [MEM_W-1:0]  wr_word;

    // Range check uses the full word index; only then is it truncated to a RAM address.
    assign word_idx  = fetch_addr[ADDR_W-1:2];
    assign fetch_oob = |(word_idx >> AW);
    assign rd_idx    = word_idx[AW-1:0];

    assign fetch_acc = (state_q == IDLE) && fetch_req && !fetch_stall && !load_start;
    assign wr_en     = (state_q == LOAD) && load_valid && !cnt_q[AW];

`ifdef INSTR_PARITY_EN
    assign wr_word = {^load_data, load_data};
`else
    assign wr_word = load_data;
`endif

    // RAM array and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[cnt_q[AW-1:0]] <= wr_word;
        end
        if (fetch_acc) begin
            rdata_q <= mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            oob_q   <= 1'b0;
            have_q  <= 1'b0;
        end else if (state_q != IDLE || load_start) begin
            valid_q <= 1'b0;
        end else if (!fetch_stall) begin
            valid_q <= fetch_req;
            if (fetch_req) begin
                mis_q  <= |fetch_addr[1:0];
                oob_q  <= fetch_oob;
                have_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            load_ready_q <= 1'b0;
            load_busy_q  <= 1'b0;
            load_done_q  <= 1'b0;
            load_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_q      <= LOAD;
                        cnt_q        <= '0;
                        load_ovf_q   <= 1'b0;
                        load_ready_q <= 1'b1;
                        load_busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        // Words past the end of the array are dropped but still counted as overflow.
                        if (!cnt_q[AW]) begin
                            cnt_q <= cnt_q + 1'b1;
                        end else begin
                            load_ovf_q <= 1'b1;
                        end
                        if (load_last) begin
                            state_q      <= DONE;
                            load_ready_q <= 1'b0;
                            load_done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    load_done_q <= 1'b0;
                    load_busy_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    load_ready_q <= 1'b0;
                    load_busy_q  <= 1'b0;
                    load_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign instr          = (have_q && !oob_q) ? rdata_q[DATA_W-1:0] : '0;
    assign instr_valid    = valid_q;
    assign misaligned_err = mis_q;
    assign oob_err        = oob_q;
`ifdef INSTR_PARITY_EN
    assign parity_err     = have_q && !oob_q && (^rdata_q);
`endif
    assign load_ready     = load_ready_q;
    assign load_busy      = load_busy_q;
    assign load_done      = load_done_q;
    assign load_overflow  = load_ovf_q;
    assign load_count     = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a 512-word instance for fetch/load behaviour and a
// 4-word instance for the overflow boundary.
module tb_instr_mem_loader;
    typedef struct {
        logic [31:0] instr;
        logic        mis;
        logic        oob;
        logic        par;
        string       name;
    } fexp_t;

    typedef struct {
        logic [31:0] cnt;
        logic        ovf;
        string       name;
    } lexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        f_req   [2];
    logic [31:0] f_addr  [2];
    logic        f_stall [2];
    logic        l_start [2];
    logic        l_valid [2];
    logic [31:0] l_data  [2];
    logic        l_last  [2];
    logic [31:0] instr_o [2];
    logic        ivalid  [2];
    logic        mis     [2];
    logic        oob     [2];
    logic        l_ready [2];
    logic        l_busy  [2];
    logic        l_done  [2];
    logic        l_ovf   [2];
`ifdef INSTR_PARITY_EN
    logic        par     [2];
`endif
    logic [9:0]  cnt0;
    logic [2:0]  cnt4;

    fexp_t fq0[$];
    fexp_t fq1[$];
    lexp_t lq0[$];
    lexp_t lq1[$];
    int n_vec = 0;
    int n_err = 0;

    instr_mem_loader #(.DATA_W(32), .DEPTH(512), .ADDR_W(32), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst(rst),
        .fetch_req(f_req[0]), .fetch_addr(f_addr[0]), .fetch_stall(f_stall[0]),
        .instr(instr_o[0]), .instr_valid(ivalid[0]), .misaligned_err(mis[0]), .oob_err(oob[0]),
`ifdef INSTR_PARITY_EN
        .parity_err(par[0]),
`endif
        .load_start(l_start[0]), .load_valid(l_valid[0]), .load_data(l_data[0]), .load_last(l_last[0]),
        .load_ready(l_ready[0]), .load_busy(l_busy[0]), .load_done(l_done[0]),
        .load_overflow(l_ovf[0]), .load_count(cnt0)
    );

    instr_mem_loader #(.DATA_W(32), .DEPTH(4), .ADDR_W(32), .INIT_FILE("")) u_dut4 (
        .clk(clk), .rst(rst),
        .fetch_req(f_req[1]), .fetch_addr(f_addr[1]), .fetch_stall(f_stall[1]),
        .instr(instr_o[1]), .instr_valid(ivalid[1]), .misaligned_err(mis[1]), .oob_err(oob[1]),
`ifdef INSTR_PARITY_EN
        .parity_err(par[1]),
`endif
        .load_start(l_start[1]), .load_valid(l_valid[1]), .load_data(l_data[1]), .load_last(l_last[1]),
        .load_ready(l_ready[1]), .load_busy(l_busy[1]), .load_done(l_done[1]),
        .load_overflow(l_ovf[1]), .load_count(cnt4)
    );

    function automatic logic [31:0] count_of(input int d);
        if (d == 0) return {22'd0, cnt0};
        return {29'd0, cnt4};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fpush(input int d, input logic [31:0] i, input logic m, input logic o,
                         input logic p, input string nm);
        fexp_t e;
        e.instr = i; e.mis = m; e.oob = o; e.par = p; e.name = nm;
        if (d == 0) fq0.push_back(e);
        else        fq1.push_back(e);
    endtask

    task automatic lpush(input int d, input logic [31:0] c, input logic o, input string nm);
        lexp_t e;
        e.cnt = c; e.ovf = o; e.name = nm;
        if (d == 0) lq0.push_back(e);
        else        lq1.push_back(e);
    endtask

    task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] ei,
                         input logic em, input logic eo, input logic ep, input string nm);
        f_req[d]  = 1'b1;
        f_addr[d] = a;
        fpush(d, ei, em, eo, ep, nm);
        tick();
        f_req[d]  = 1'b0;
    endtask

    task automatic lstart(input int d);
        l_start[d] = 1'b1;
        tick();
        l_start[d] = 1'b0;
    endtask

    task automatic lword(input int d, input logic [31:0] w, input logic last);
        l_valid[d] = 1'b1;
        l_data[d]  = w;
        l_last[d]  = last;
        tick();
        l_valid[d] = 1'b0;
        l_last[d]  = 1'b0;
    endtask

    task automatic wait_idle(input int d, input string nm);
        int n = 0;
        while (l_busy[d] && n < 20) begin
            tick();
            n++;
        end
        chk(nm, 32'(l_busy[d]), 32'd0);
    endtask

    task automatic chk_reset(input int d, input string nm);
        chk({nm, "_instr"}, instr_o[d], 32'd0);
        chk({nm, "_valid"}, 32'(ivalid[d]), 32'd0);
        chk({nm, "_mis"},   32'(mis[d]), 32'd0);
        chk({nm, "_oob"},   32'(oob[d]), 32'd0);
        chk({nm, "_ready"}, 32'(l_ready[d]), 32'd0);
        chk({nm, "_busy"},  32'(l_busy[d]), 32'd0);
        chk({nm, "_done"},  32'(l_done[d]), 32'd0);
        chk({nm, "_ovf"},   32'(l_ovf[d]), 32'd0);
        chk({nm, "_count"}, count_of(d), 32'd0);
`ifdef INSTR_PARITY_EN
        chk({nm, "_par"},   32'(par[d]), 32'd0);
`endif
    endtask

    // Monitors: one per instance, popping the scoreboards whenever an output is presented.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        logic done_prev = 1'b0;
        always @(negedge clk) begin
            fexp_t fe;
            lexp_t le;
            int    fsz;
            int    lsz;
            fsz = (gi == 0) ? fq0.size() : fq1.size();
            lsz = (gi == 0) ? lq0.size() : lq1.size();
            if (!rst && ivalid[gi]) begin
                if (fsz == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_fetch dut%0d: got instr %h, required no output", gi, instr_o[gi]);
                end else begin
                    fe = (gi == 0) ? fq0.pop_front() : fq1.pop_front();
                    chk({fe.name, "_instr"}, instr_o[gi], fe.instr);
                    chk({fe.name, "_mis"}, 32'(mis[gi]), 32'(fe.mis));
                    chk({fe.name, "_oob"}, 32'(oob[gi]), 32'(fe.oob));
`ifdef INSTR_PARITY_EN
                    chk({fe.name, "_par"}, 32'(par[gi]), 32'(fe.par));
`endif
                end
            end
            if (!rst && l_done[gi]) begin
                chk("done_single_pulse", 32'(done_prev), 32'd0);
                if (lsz == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done dut%0d: got load_done 1, required 0", gi);
                end else begin
                    le = (gi == 0) ? lq0.pop_front() : lq1.pop_front();
                    chk({le.name, "_count"}, count_of(gi), le.cnt);
                    chk({le.name, "_ovf"}, 32'(l_ovf[gi]), 32'(le.ovf));
                end
            end
            done_prev = l_done[gi];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            f_req[d] = 1'b0; f_addr[d] = '0; f_stall[d] = 1'b0;
            l_start[d] = 1'b0; l_valid[d] = 1'b0; l_data[d] = '0; l_last[d] = 1'b0;
        end
        repeat (3) tick();
        chk_reset(0, "rst0");
        chk_reset(1, "rst4");
        rst = 1'b0;
        tick();

        // Program image, then back-to-back fetches
        lstart(0);
        chk("load_ready", 32'(l_ready[0]), 32'd1);
        lword(0, 32'h00500093, 1'b0);
        lword(0, 32'h00A00113, 1'b0);
        lword(0, 32'h002081B3, 1'b0);
        lpush(0, 32'd4, 1'b0, "img");
        lword(0, 32'h0000006F, 1'b1);
        wait_idle(0, "img_idle");
        fetch(0, 32'h0, 32'h00500093, 1'b0, 1'b0, 1'b0, "f0");
        fetch(0, 32'h4, 32'h00A00113, 1'b0, 1'b0, 1'b0, "f4");
        fetch(0, 32'h8, 32'h002081B3, 1'b0, 1'b0, 1'b0, "f8");
        fetch(0, 32'hC, 32'h0000006F, 1'b0, 1'b0, 1'b0, "fC");
        fetch(0, 32'h6, 32'h00A00113, 1'b1, 1'b0, 1'b0, "mis6");
        fetch(0, 32'h800, 32'h0, 1'b0, 1'b1, 1'b0, "oob800");
        fetch(0, 32'h8, 32'h002081B3, 1'b0, 1'b0, 1'b0, "stall_f8");

        // Stall holds the result while the address moves
        f_stall[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f_req[0]  = 1'b1;
            f_addr[0] = 32'h10 + 32'(i) * 32'h4 + 32'h1;
            fpush(0, 32'h002081B3, 1'b0, 1'b0, 1'b0, "stall_hold");
            tick();
        end
        f_stall[0] = 1'b0;
        f_req[0]   = 1'b0;
        tick();
        chk("idle_valid", 32'(ivalid[0]), 32'd0);
        chk("idle_instr_kept", instr_o[0], 32'h002081B3);

        // Load with a load_valid gap
        lstart(0);
        lword(0, 32'h11, 1'b0);
        tick();
        lword(0, 32'h22, 1'b0);
        lpush(0, 32'd3, 1'b0, "gap3");
        lword(0, 32'h33, 1'b1);
        wait_idle(0, "gap_idle");
        fetch(0, 32'h4, 32'h22, 1'b0, 1'b0, 1'b0, "after_load4");
        fetch(0, 32'h0, 32'h11, 1'b0, 1'b0, 1'b0, "after_load0");
        fetch(0, 32'hC, 32'h0000006F, 1'b0, 1'b0, 1'b0, "after_loadC");

        // Simultaneous load_start and fetch_req: load wins
        f_req[0] = 1'b1; f_addr[0] = 32'h0; l_start[0] = 1'b1;
        tick();
        f_req[0] = 1'b0; l_start[0] = 1'b0;
        chk("sim_valid", 32'(ivalid[0]), 32'd0);
        chk("sim_busy", 32'(l_busy[0]), 32'd1);
        lpush(0, 32'd1, 1'b0, "single");
        lword(0, 32'h55, 1'b1);
        wait_idle(0, "single_idle");

        // Reset during a partial load
        lstart(0);
        lword(0, 32'hA0, 1'b0);
        lword(0, 32'hA1, 1'b0);
        rst = 1'b1;
        #1;
        chk_reset(0, "midrst");
        tick();
        rst = 1'b0;
        tick();
        fetch(0, 32'h0, 32'hA0, 1'b0, 1'b0, 1'b0, "partial_w0");
        fetch(0, 32'h4, 32'hA1, 1'b0, 1'b0, 1'b0, "partial_w1");
        fetch(0, 32'h8, 32'h33, 1'b0, 1'b0, 1'b0, "partial_w2_kept");
`ifdef INSTR_PARITY_EN
        u_dut0.mem_q[1] = u_dut0.mem_q[1] ^ 33'd1;
        fetch(0, 32'h4, 32'hA0, 1'b0, 1'b0, 1'b1, "par_flip");
        fetch(0, 32'h0, 32'hA0, 1'b0, 1'b0, 1'b0, "par_clean");
`endif

        // DEPTH=4: six words offered, only four stored
        lstart(1);
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) lpush(1, 32'd4, 1'b1, "ovf");
            lword(1, 32'(i), (i == 6));
        end
        wait_idle(1, "ovf_idle");
        fetch(1, 32'h0,  32'd1, 1'b0, 1'b0, 1'b0, "d4_w0");
        fetch(1, 32'h4,  32'd2, 1'b0, 1'b0, 1'b0, "d4_w1");
        fetch(1, 32'h8,  32'd3, 1'b0, 1'b0, 1'b0, "d4_w2");
        fetch(1, 32'hC,  32'd4, 1'b0, 1'b0, 1'b0, "d4_w3");
        fetch(1, 32'h10, 32'd0, 1'b0, 1'b1, 1'b0, "d4_oob");
        fetch(1, 32'hE,  32'd4, 1'b1, 1'b0, 1'b0, "d4_mis");

        repeat (3) tick();
        chk("fetch_sb_drained0", 32'(fq0.size()), 32'd0);
        chk("fetch_sb_drained4", 32'(fq1.size()), 32'd0);
        chk("load_sb_drained0", 32'(lq0.size()), 32'd0);
        chk("load_sb_drained4", 32'(lq1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
